ftab_seg_rd_arb2: RTL
=====================

FTAB_SEG_RD_ARB2 -- requirements
Module: ftab_seg_rd_arb2

Interface
REQ-001 Parameter AW, 10, segment address width.
REQ-002 Parameter DW, 8, segment data width.
REQ-003 Parameter FD, 4, owner-FIFO depth (power of two, 2..16); max outstanding reads.
REQ-004 The block SHALL use one clock and an asynchronous active-low reset: port clock, port reset.
REQ-005 clock  in  1  rising-edge clock.
REQ-006 reset  in  1  async active-low reset.
REQ-007 rN_addr_e / rN_addr_v / rN_addr  in  1/1/AW  requester N (N=0,1) address stream: eos, valid, value.
REQ-008 rN_addr_b  out  1  requester N address backpressure.
REQ-009 rN_data_e / rN_data_v / rN_data  out  1/1/DW  requester N return stream: eos, valid, value.
REQ-010 rN_data_b  in  1  requester N return backpressure.
REQ-011 segment_r_addr_e / segment_r_addr_v / segment_r_addr  out  1/1/AW  shared segment read address.
REQ-012 segment_r_addr_b  in  1  segment address backpressure.
REQ-013 segment_r_data_e / segment_r_data_v / segment_r_data  in  1/1/DW  segment read data.
REQ-014 segment_r_data_b  out  1  segment data backpressure.

Function
REQ-015 Token transfer on any stream SHALL occur exactly in cycles where v=1 and b=0; all handshake outputs SHALL be combinational in current state and inputs.
REQ-016 Owner FIFO SHALL hold FD entries {owner (1b), is_eos (1b)}, in issue order.
REQ-017 Requester N SHALL be eligible when rN_addr_v=1, FIFO not full, and (rN_addr_e=1 or segment_r_addr_b=0).
REQ-018 At most one requester SHALL be granted per cycle; if both eligible, grant the one not granted most recently (rr pointer, reset favours r0); rr pointer updates only on a grant.
REQ-019 Grant of a data token (e=0): rN_addr_b=0, segment_r_addr_v=1, segment_r_addr_e=0, segment_r_addr=rN_addr, push {N,0}.
REQ-020 Grant of an eos token (e=1): rN_addr_b=0, no segment access, push {N,1}; requester N then SHALL be held off (rN_addr_b=1) until reset.
REQ-021 Non-granted requesters SHALL see rN_addr_b=1; segment_r_addr_e SHALL never be 1.
REQ-022 FIFO full SHALL block all pushes even if a pop occurs the same cycle; push and pop in the same non-full cycle SHALL both take effect (count unchanged).
REQ-023 Head {N,0}: when segment_r_data_v=1, segment_r_data_e=0, rN_data_b=0: segment_r_data_b=0, rN_data_v=1, rN_data_e=0, rN_data=segment_r_data, pop.
REQ-024 Head {N,1}: when rN_data_b=0: rN_data_v=1, rN_data_e=1, rN_data=0, pop; segment_r_data_b stays 1.
REQ-025 Segment data with segment_r_data_e=1 SHALL be consumed (segment_r_data_b=0) and discarded without popping, regardless of head state.
REQ-026 FIFO empty: segment_r_data_b=1 except per REQ-025; all rN_data_v=0.
REQ-027 Defaults when not driven above: all _v=0, all _e=0, all _b=1, data/address outputs 0.
REQ-028 Return data SHALL never overtake: requester-visible order equals issue order per requester.

Reset
REQ-029 While reset=0: FIFO empty, rr pointer favours r0, eos-retired flags clear; all _v outputs 0, all _b outputs 1, all _e 0.
REQ-030 Reset asserted mid-operation SHALL discard all outstanding entries; segment data arriving after release with FIFO empty SHALL be backpressured (not forwarded).

Verification
REQ-031 r0 addr 0x005, segment returns 0xA7 one cycle later -> segment_r_addr=0x005 cycle 0; r0_data=0xA7, v=1 cycle 1; r1 untouched.
REQ-032 r0 and r1 valid every cycle, segment never busy, data returns next cycle -> grants alternate r1,r0,r1... after first r0; each data routed to correct owner, count never exceeds FD.
REQ-033 segment_r_data_v held 0 for 10 cycles, both requesters streaming -> exactly FD addresses issued, then both rN_addr_b=1 until data drains.
REQ-034 r1 sends addr 0x010, then eos; r1_data_b=1 for 3 cycles after data arrives -> data 0x010-lookup then eos delivered to r1 in order; r1_addr_b=1 thereafter; r0 continues unaffected.
REQ-035 Two reads outstanding, reset pulsed low 1 cycle -> all outputs reset values during pulse; pending segment data after release not forwarded; new r0 read completes normally.

Source files
------------

// File: rtl/ftab_seg_rd_arb2.sv
// Two-requester round-robin arbiter onto one shared segment read port.
// An owner FIFO remembers who issued each read (or eos) so returns are routed in issue order.
module ftab_seg_rd_arb2 #(
    parameter int AW = 10,
    parameter int DW = 8,
    parameter int FD = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          r0_addr_e,
    input  logic          r0_addr_v,
    input  logic [AW-1:0] r0_addr,
    output logic          r0_addr_b,
    output logic          r0_data_e,
    output logic          r0_data_v,
    output logic [DW-1:0] r0_data,
    input  logic          r0_data_b,
    input  logic          r1_addr_e,
    input  logic          r1_addr_v,
    input  logic [AW-1:0] r1_addr,
    output logic          r1_addr_b,
    output logic          r1_data_e,
    output logic          r1_data_v,
    output logic [DW-1:0] r1_data,
    input  logic          r1_data_b,
    output logic          segment_r_addr_e,
    output logic          segment_r_addr_v,
    output logic [AW-1:0] segment_r_addr,
    input  logic          segment_r_addr_b,
    input  logic          segment_r_data_e,
    input  logic          segment_r_data_v,
    input  logic [DW-1:0] segment_r_data,
    output logic          segment_r_data_b
);
    // Handshake: a token moves on any stream only in a cycle with v=1 and b=0.
    localparam int PW = $clog2(FD);
    localparam logic [PW:0]   LP_FULL  = (PW+1)'(FD);
    localparam logic [PW:0]   LP_ONE_C = (PW+1)'(1);
    localparam logic [PW-1:0] LP_ONE_P = PW'(1);

    logic [FD-1:0] r_own;
    logic [FD-1:0] r_eos;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_cnt;
    logic          r_rr;
    logic [1:0]    r_retired;

    logic          w_full;
    logic          w_empty;
    logic          w_elig0;
    logic          w_elig1;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_push;
    logic          w_push_eos;
    logic [AW-1:0] w_gaddr;
    logic          w_head_own;
    logic          w_head_eos;
    logic          w_head_b;
    logic          w_seg_disc;
    logic          w_pop_eos;
    logic          w_pop_dat;
    logic          w_pop;

    assign w_full  = (r_cnt == LP_FULL);
    assign w_empty = (r_cnt == '0);

    // A full FIFO blocks pushes even when a pop happens in the same cycle.
    assign w_elig0 = reset && r0_addr_v && !r_retired[0] && !w_full && (r0_addr_e || !segment_r_addr_b);
    assign w_elig1 = reset && r1_addr_v && !r_retired[1] && !w_full && (r1_addr_e || !segment_r_addr_b);
    assign w_gnt0  = w_elig0 && (!w_elig1 || !r_rr);
    assign w_gnt1  = w_elig1 && (!w_elig0 || r_rr);

    assign w_push     = w_gnt0 || w_gnt1;
    assign w_push_eos = w_gnt1 ? r1_addr_e : r0_addr_e;
    assign w_gaddr    = w_gnt1 ? r1_addr : r0_addr;

    assign r0_addr_b        = !w_gnt0;
    assign r1_addr_b        = !w_gnt1;
    assign segment_r_addr_e = 1'b0;
    assign segment_r_addr_v = w_push && !w_push_eos;
    assign segment_r_addr   = segment_r_addr_v ? w_gaddr : '0;

    assign w_head_own = r_own[r_rptr];
    assign w_head_eos = r_eos[r_rptr];
    assign w_head_b   = w_head_own ? r1_data_b : r0_data_b;

    // Segment-side eos tokens carry no read result; swallow them without touching the FIFO.
    assign w_seg_disc = reset && segment_r_data_v && segment_r_data_e;
    assign w_pop_eos  = reset && !w_empty && w_head_eos && !w_head_b;
    assign w_pop_dat  = reset && !w_empty && !w_head_eos && segment_r_data_v
                        && !segment_r_data_e && !w_head_b;
    assign w_pop      = w_pop_eos || w_pop_dat;

    assign segment_r_data_b = !(w_seg_disc || w_pop_dat);

    always_comb begin
        r0_data_v = 1'b0;
        r0_data_e = 1'b0;
        r0_data   = '0;
        r1_data_v = 1'b0;
        r1_data_e = 1'b0;
        r1_data   = '0;
        if (w_pop) begin
            if (w_head_own) begin
                r1_data_v = 1'b1;
                r1_data_e = w_head_eos;
                r1_data   = w_head_eos ? '0 : segment_r_data;
            end else begin
                r0_data_v = 1'b1;
                r0_data_e = w_head_eos;
                r0_data   = w_head_eos ? '0 : segment_r_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_own     <= '0;
            r_eos     <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_cnt     <= '0;
            r_rr      <= 1'b0;
            r_retired <= '0;
        end else begin
            if (w_push) begin
                r_own[r_wptr] <= w_gnt1;
                r_eos[r_wptr] <= w_push_eos;
                r_wptr        <= r_wptr + LP_ONE_P;
                // r_rr=1 means r1 wins the next tie.
                r_rr          <= w_gnt0;
            end
            if (w_gnt0 && r0_addr_e) r_retired[0] <= 1'b1;
            if (w_gnt1 && r1_addr_e) r_retired[1] <= 1'b1;
            if (w_pop) r_rptr <= r_rptr + LP_ONE_P;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + LP_ONE_C;
                2'b01:   r_cnt <= r_cnt - LP_ONE_C;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule
